// File: rtl/cpu_core.sv
// Five-stage in-order MIPS-subset pipeline (IF, ID, EX, MEM, WB) with EX operand
// forwarding, a one-cycle load-use stall and branch resolution in EX.
module cpu_core #(
    parameter int ADDRESS_SIZE = 32,
    parameter int DATA_SIZE    = 32
) (
    input  logic                    clock,
    input  logic                    reset_n,
    output logic                    im_write_enable,
    output logic [ADDRESS_SIZE-1:0] im_write_address,
    output logic [DATA_SIZE-1:0]    im_write_data,
    output logic [ADDRESS_SIZE-1:0] im_read_address,
    input  logic [DATA_SIZE-1:0]    im_read_data,
    output logic                    dm_write_enable,
    output logic [ADDRESS_SIZE-1:0] dm_write_address,
    output logic [DATA_SIZE-1:0]    dm_write_data,
    output logic [ADDRESS_SIZE-1:0] dm_read_address,
    input  logic [DATA_SIZE-1:0]    dm_read_data
);

    typedef enum logic [3:0] {
        OP_NOP  = 4'd0,
        OP_ADD  = 4'd1,
        OP_SUB  = 4'd2,
        OP_AND  = 4'd3,
        OP_OR   = 4'd4,
        OP_SLT  = 4'd5,
        OP_ADDI = 4'd6,
        OP_LW   = 4'd7,
        OP_SW   = 4'd8,
        OP_BEQ  = 4'd9
    } opKind_t;

    localparam int REGS = 32;

    logic [ADDRESS_SIZE-1:0] pc_q, pc_d;
    logic [DATA_SIZE-1:0]    ifIdIr_q, ifIdIr_d;
    logic [ADDRESS_SIZE-1:0] ifIdPc_q, ifIdPc_d;

    logic [DATA_SIZE-1:0]    idExA_q, idExB_q, idExImm_q;
    logic [4:0]              idExRs_q, idExRt_q, idExRd_q;
    opKind_t                 idExOp_q;
    logic [ADDRESS_SIZE-1:0] idExPc_q;

    logic [DATA_SIZE-1:0]    exMemResult_q, exMemB_q;
    logic [4:0]              exMemDest_q;
    opKind_t                 exMemOp_q;
    logic                    exMemValid_q;

    logic [DATA_SIZE-1:0]    memWbResult_q, memWbData_q;
    logic [4:0]              memWbDest_q;
    opKind_t                 memWbOp_q;
    logic                    memWbValid_q;

    logic [DATA_SIZE-1:0]    regs_q [REGS];

    logic [4:0]              idRs, idRt, idRd;
    opKind_t                 idOp;
    logic [DATA_SIZE-1:0]    idImm, idRegA, idRegB;

    logic [DATA_SIZE-1:0]    exA, exB, exResult_d;
    logic [4:0]              exDest_d;
    logic                    exValid_d;
    logic                    branchTaken;
    logic [ADDRESS_SIZE-1:0] branchTarget;

    logic [4:0]              wbDest;
    logic [DATA_SIZE-1:0]    wbValue;
    logic                    wbWeEnable;

    logic                    loadUse, ex_stall_c, mem_stall_c, hold;

    function automatic opKind_t decodeOp(input logic [31:0] ir);
        opKind_t op;
        op = OP_NOP;
        case (ir[31:26])
            6'h00: begin
                case (ir[5:0])
                    6'h20:   op = OP_ADD;
                    6'h22:   op = OP_SUB;
                    6'h24:   op = OP_AND;
                    6'h25:   op = OP_OR;
                    6'h2A:   op = OP_SLT;
                    default: op = OP_NOP;
                endcase
            end
            6'h08:   op = OP_ADDI;
            6'h23:   op = OP_LW;
            6'h2B:   op = OP_SW;
            6'h04:   op = OP_BEQ;
            default: op = OP_NOP;
        endcase
        return op;
    endfunction

    assign im_write_enable  = 1'b0;
    assign im_write_address = '0;
    assign im_write_data    = '0;
    assign im_read_address  = pc_q;

    assign idRs  = ifIdIr_q[25:21];
    assign idRt  = ifIdIr_q[20:16];
    assign idRd  = ifIdIr_q[15:11];
    assign idOp  = decodeOp(ifIdIr_q[31:0]);
    assign idImm = {{(DATA_SIZE-16){ifIdIr_q[15]}}, ifIdIr_q[15:0]};

    // Register read sees a same-cycle WB write, so WB->ID needs no extra forwarding.
    always_comb begin
        idRegA = regs_q[idRs];
        idRegB = regs_q[idRt];
        if (wbWeEnable && (wbDest == idRs)) idRegA = wbValue;
        if (wbWeEnable && (wbDest == idRt)) idRegB = wbValue;
        if (idRs == 5'd0) idRegA = '0;
        if (idRt == 5'd0) idRegB = '0;
    end

    assign wbDest     = memWbDest_q;
    assign wbValue    = (memWbOp_q == OP_LW) ? memWbData_q : memWbResult_q;
    assign wbWeEnable = memWbValid_q && (wbDest != 5'd0);

    // A load in EX_MEM has no data yet; the load-use stall covers that case.
    always_comb begin
        exA = idExA_q;
        exB = idExB_q;
        if (exMemValid_q && (exMemOp_q != OP_LW) && (exMemDest_q != 5'd0) && (exMemDest_q == idExRs_q))
            exA = exMemResult_q;
        else if (memWbValid_q && (memWbDest_q != 5'd0) && (memWbDest_q == idExRs_q))
            exA = wbValue;
        if (exMemValid_q && (exMemOp_q != OP_LW) && (exMemDest_q != 5'd0) && (exMemDest_q == idExRt_q))
            exB = exMemResult_q;
        else if (memWbValid_q && (memWbDest_q != 5'd0) && (memWbDest_q == idExRt_q))
            exB = wbValue;
    end

    always_comb begin
        exResult_d = '0;
        exDest_d   = 5'd0;
        exValid_d  = 1'b0;
        case (idExOp_q)
            OP_ADD: begin
                exResult_d = exA + exB;
                exDest_d   = idExRd_q;
                exValid_d  = 1'b1;
            end
            OP_SUB: begin
                exResult_d = exA - exB;
                exDest_d   = idExRd_q;
                exValid_d  = 1'b1;
            end
            OP_AND: begin
                exResult_d = exA & exB;
                exDest_d   = idExRd_q;
                exValid_d  = 1'b1;
            end
            OP_OR: begin
                exResult_d = exA | exB;
                exDest_d   = idExRd_q;
                exValid_d  = 1'b1;
            end
            OP_SLT: begin
                exResult_d = {{(DATA_SIZE-1){1'b0}}, ($signed(exA) < $signed(exB))};
                exDest_d   = idExRd_q;
                exValid_d  = 1'b1;
            end
            OP_ADDI, OP_LW: begin
                exResult_d = exA + idExImm_q;
                exDest_d   = idExRt_q;
                exValid_d  = 1'b1;
            end
            OP_SW: begin
                exResult_d = exA + idExImm_q;
            end
            default: begin
                exResult_d = '0;
            end
        endcase
    end

    // idExPc_q already holds the BEQ address + 1.
    assign branchTaken  = (idExOp_q == OP_BEQ) && (exA == exB);
    assign branchTarget = idExPc_q + {{(ADDRESS_SIZE-16){idExImm_q[15]}}, idExImm_q[15:0]};

    assign loadUse     = (idExOp_q == OP_LW) && ((idExRt_q == idRs) || (idExRt_q == idRt));
    assign ex_stall_c  = loadUse && !branchTaken;
    assign mem_stall_c = 1'b0;
    assign hold        = ex_stall_c || mem_stall_c;

    always_comb begin
        pc_d     = pc_q + ADDRESS_SIZE'(1);
        ifIdIr_d = im_read_data;
        ifIdPc_d = pc_q + ADDRESS_SIZE'(1);
        if (branchTaken) begin
            pc_d     = branchTarget;
            ifIdIr_d = '0;
            ifIdPc_d = '0;
        end else if (hold) begin
            pc_d     = pc_q;
            ifIdIr_d = ifIdIr_q;
            ifIdPc_d = ifIdPc_q;
        end
    end

    assign dm_read_address  = ADDRESS_SIZE'(exMemResult_q);
    assign dm_write_address = ADDRESS_SIZE'(exMemResult_q);
    assign dm_write_data    = exMemB_q;
    assign dm_write_enable  = reset_n && (exMemOp_q == OP_SW);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            pc_q          <= '0;
            ifIdIr_q      <= '0;
            ifIdPc_q      <= '0;
            idExA_q       <= '0;
            idExB_q       <= '0;
            idExImm_q     <= '0;
            idExRs_q      <= 5'd0;
            idExRt_q      <= 5'd0;
            idExRd_q      <= 5'd0;
            idExOp_q      <= OP_NOP;
            idExPc_q      <= '0;
            exMemResult_q <= '0;
            exMemB_q      <= '0;
            exMemDest_q   <= 5'd0;
            exMemOp_q     <= OP_NOP;
            exMemValid_q  <= 1'b0;
            memWbResult_q <= '0;
            memWbData_q   <= '0;
            memWbDest_q   <= 5'd0;
            memWbOp_q     <= OP_NOP;
            memWbValid_q  <= 1'b0;
            for (int i = 0; i < REGS; i++) regs_q[i] <= '0;
        end else begin
            pc_q     <= pc_d;
            ifIdIr_q <= ifIdIr_d;
            ifIdPc_q <= ifIdPc_d;

            idExA_q   <= idRegA;
            idExB_q   <= idRegB;
            idExImm_q <= idImm;
            idExPc_q  <= ifIdPc_q;
            if (branchTaken || hold) begin
                idExOp_q <= OP_NOP;
                idExRs_q <= 5'd0;
                idExRt_q <= 5'd0;
                idExRd_q <= 5'd0;
            end else begin
                idExOp_q <= idOp;
                idExRs_q <= idRs;
                idExRt_q <= idRt;
                idExRd_q <= idRd;
            end

            exMemResult_q <= exResult_d;
            exMemB_q      <= exB;
            exMemDest_q   <= exDest_d;
            exMemOp_q     <= idExOp_q;
            exMemValid_q  <= exValid_d;

            memWbResult_q <= exMemResult_q;
            memWbData_q   <= dm_read_data;
            memWbDest_q   <= exMemDest_q;
            memWbOp_q     <= exMemOp_q;
            memWbValid_q  <= exMemValid_q;

            if (wbWeEnable) regs_q[wbDest] <= wbValue;
        end
    end

endmodule

// File: tb/tb_cpu_core.sv
// Directed bench for cpu_core: a small program in a behavioural instruction/data
// memory, with writeback, hazard and reset behaviour checked at known cycles.
module tb_cpu_core;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          im_write_enable;
    logic [AW-1:0] im_write_address;
    logic [DW-1:0] im_write_data;
    logic [AW-1:0] im_read_address;
    logic [DW-1:0] im_read_data;
    logic          dm_write_enable;
    logic [AW-1:0] dm_write_address;
    logic [DW-1:0] dm_write_data;
    logic [AW-1:0] dm_read_address;
    logic [DW-1:0] dm_read_data;

    logic [DW-1:0] im [64];
    logic [DW-1:0] dm [64];

    int checks = 0;
    int errors = 0;
    int cycle = 0;
    int stallCount = 0;
    int stallCycle = -1;
    int dmWrites = 0;

    cpu_core #(.ADDRESS_SIZE(AW), .DATA_SIZE(DW)) dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .im_write_enable  (im_write_enable),
        .im_write_address (im_write_address),
        .im_write_data    (im_write_data),
        .im_read_address  (im_read_address),
        .im_read_data     (im_read_data),
        .dm_write_enable  (dm_write_enable),
        .dm_write_address (dm_write_address),
        .dm_write_data    (dm_write_data),
        .dm_read_address  (dm_read_address),
        .dm_read_data     (dm_read_data)
    );

    always #5 clock = ~clock;

    assign im_read_data = (im_read_address < 64) ? im[im_read_address[5:0]] : '0;
    assign dm_read_data = (dm_read_address < 64) ? dm[dm_read_address[5:0]] : '0;

    always @(posedge clock) begin
        if (dm_write_enable) begin
            dmWrites++;
            if (dm_write_address < 64) dm[dm_write_address[5:0]] = dm_write_data;
        end
    end

    always @(negedge clock) begin
        if (reset_n && dut.ex_stall_c) begin
            stallCount++;
            stallCycle = cycle;
        end
    end

    function automatic logic [31:0] encR(input int rs, input int rt, input int rd, input logic [5:0] funct);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, funct};
    endfunction

    function automatic logic [31:0] encI(input logic [5:0] opc, input int rs, input int rt, input logic [15:0] imm);
        return {opc, 5'(rs), 5'(rt), imm};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Advance to absolute cycle 'target' (cycle n = n rising edges after reset release).
    task automatic applyStimulus(input int target);
        while (cycle < target) begin
            @(posedge clock);
            #1;
            cycle++;
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            im[i] = 32'h0;
            dm[i] = 32'h0;
        end
        im[0]  = encI(6'h08, 0, 1, 16'd5);
        im[1]  = encI(6'h08, 0, 2, 16'd7);
        im[2]  = encR(1, 2, 3, 6'h20);
        im[3]  = encI(6'h2B, 0, 3, 16'd0);
        im[4]  = encI(6'h23, 0, 4, 16'd0);
        im[5]  = encR(4, 4, 5, 6'h20);
        im[6]  = encI(6'h04, 0, 0, 16'd2);
        im[7]  = encI(6'h08, 0, 6, 16'd1);
        im[8]  = encI(6'h08, 0, 6, 16'd1);
        im[9]  = encI(6'h08, 0, 7, 16'd9);
        im[10] = encI(6'h08, 0, 0, 16'd3);
        im[11] = encR(1, 2, 8, 6'h22);
        im[12] = encR(8, 1, 9, 6'h2A);
        im[13] = encR(3, 2, 10, 6'h24);
        im[14] = encR(3, 1, 11, 6'h25);
        im[15] = encI(6'h04, 1, 2, 16'd5);
        im[16] = encI(6'h08, 1, 12, 16'hFFFF);
        im[17] = encI(6'h08, 0, 13, 16'h8000);

        $display("[TB] reset and program run");
        reset_n = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        checkOutput("rst_pc", dut.pc_q, 32'd0);
        checkOutput("rst_exmem_valid", dut.exMemValid_q, 32'd0);
        checkOutput("rst_memwb_valid", dut.memWbValid_q, 32'd0);
        checkOutput("rst_idex_op", dut.idExOp_q, 32'd0);
        checkOutput("rst_stall", dut.ex_stall_c, 32'd0);
        checkOutput("rst_dm_we", dm_write_enable, 32'd0);
        checkOutput("rst_im_we", im_write_enable, 32'd0);
        checkOutput("rst_im_waddr", im_write_address, 32'd0);
        checkOutput("rst_im_wdata", im_write_data, 32'd0);
        checkOutput("rst_r1", dut.regs_q[1], 32'd0);
        reset_n = 1'b1;
        cycle = 0;
        checkOutput("first_fetch_addr", im_read_address, 32'd0);

        applyStimulus(1);
        checkOutput("ifid_ir_c1", dut.ifIdIr_q, 32'h20010005);

        applyStimulus(4);
        checkOutput("addi_wb_dest", dut.wbDest, 32'd1);
        checkOutput("addi_wb_value", dut.wbValue, 32'd5);
        checkOutput("addi_wb_we", dut.wbWeEnable, 32'd1);

        applyStimulus(6);
        checkOutput("add_fwd_dest", dut.wbDest, 32'd3);
        checkOutput("add_fwd_value", dut.wbValue, 32'd12);
        checkOutput("no_stall_before_lw", stallCount, 32'd0);
        checkOutput("loaduse_stall", dut.ex_stall_c, 32'd1);
        checkOutput("sw_we", dm_write_enable, 32'd1);
        checkOutput("sw_addr", dm_write_address, 32'd0);
        checkOutput("sw_data", dm_write_data, 32'd12);

        applyStimulus(7);
        checkOutput("stall_released", dut.ex_stall_c, 32'd0);
        checkOutput("pc_held", im_read_address, 32'd6);
        checkOutput("dm0_written", dm[0], 32'd12);

        applyStimulus(8);
        checkOutput("lw_wb_dest", dut.wbDest, 32'd4);
        checkOutput("lw_wb_value", dut.wbValue, 32'd12);

        applyStimulus(10);
        checkOutput("loaduse_add_dest", dut.wbDest, 32'd5);
        checkOutput("loaduse_add_value", dut.wbValue, 32'd24);
        checkOutput("branch_target_fetch", im_read_address, 32'd9);

        applyStimulus(14);
        checkOutput("after_branch_dest", dut.wbDest, 32'd7);
        checkOutput("after_branch_value", dut.wbValue, 32'd9);

        applyStimulus(15);
        checkOutput("r0_wb_dest", dut.wbDest, 32'd0);
        checkOutput("r0_wb_we", dut.wbWeEnable, 32'd0);

        applyStimulus(21);
        checkOutput("not_taken_dest", dut.wbDest, 32'd12);
        checkOutput("not_taken_value", dut.wbValue, 32'd4);

        applyStimulus(26);
        checkOutput("r0", dut.regs_q[0], 32'd0);
        checkOutput("r3", dut.regs_q[3], 32'd12);
        checkOutput("r4", dut.regs_q[4], 32'd12);
        checkOutput("r5", dut.regs_q[5], 32'd24);
        checkOutput("r6_flushed", dut.regs_q[6], 32'd0);
        checkOutput("r7", dut.regs_q[7], 32'd9);
        checkOutput("r8_sub", dut.regs_q[8], 32'hFFFFFFFE);
        checkOutput("r9_slt", dut.regs_q[9], 32'd1);
        checkOutput("r10_and", dut.regs_q[10], 32'd4);
        checkOutput("r11_or", dut.regs_q[11], 32'd13);
        checkOutput("r12_addi_neg", dut.regs_q[12], 32'd4);
        checkOutput("r13_addi_min", dut.regs_q[13], 32'hFFFF8000);
        checkOutput("stall_count", stallCount, 32'd1);
        checkOutput("stall_cycle", stallCycle, 32'd6);
        checkOutput("dm_write_count", dmWrites, 32'd1);

        $display("[TB] mid-program reset");
        dm[0] = 32'hDEAD;
        reset_n = 1'b0;
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        cycle = 0;
        applyStimulus(6);
        checkOutput("rerun_sw_inflight", dm_write_enable, 32'd1);
        reset_n = 1'b0;
        #1;
        checkOutput("reset_blocks_dm_we", dm_write_enable, 32'd0);
        @(posedge clock);
        #1;
        checkOutput("mid_rst_pc", dut.pc_q, 32'd0);
        checkOutput("mid_rst_ifid", dut.ifIdIr_q, 32'd0);
        checkOutput("mid_rst_idex_op", dut.idExOp_q, 32'd0);
        checkOutput("mid_rst_exmem_valid", dut.exMemValid_q, 32'd0);
        checkOutput("mid_rst_memwb_valid", dut.memWbValid_q, 32'd0);
        checkOutput("mid_rst_dm0_kept", dm[0], 32'hDEAD);
        checkOutput("mid_rst_r3", dut.regs_q[3], 32'd0);
        checkOutput("mid_rst_writes", dmWrites, 32'd1);
        reset_n = 1'b1;
        cycle = 0;
        checkOutput("refetch_addr", im_read_address, 32'd0);
        applyStimulus(1);
        checkOutput("refetch_ir", dut.ifIdIr_q, 32'h20010005);
        applyStimulus(4);
        checkOutput("refetch_wb_dest", dut.wbDest, 32'd1);
        checkOutput("refetch_wb_value", dut.wbValue, 32'd5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cpu_core.md
CPU_CORE -- requirements
Module: cpu_core

Interface
REQ-001 The block SHALL have parameter ADDRESS_SIZE, default 32, meaning the memory address width.
REQ-002 The block SHALL have parameter DATA_SIZE, default 32, meaning the instruction, data and register width.
REQ-003 The block SHALL use one clock and a synchronous, active-low reset.
REQ-004 The block SHALL have port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port reset_n, input, 1 bit: synchronous, active-low reset.
REQ-006 The block SHALL have ports im_write_enable (1 bit), im_write_address (ADDRESS_SIZE) and im_write_data (DATA_SIZE), all outputs: instruction-memory write port, driven constant 0.
REQ-007 The block SHALL have port im_read_address, output, ADDRESS_SIZE bits: equal to PC.
REQ-008 The block SHALL have port im_read_data, input, DATA_SIZE bits: instruction at im_read_address, valid in the same cycle (combinational read).
REQ-009 The block SHALL have ports dm_write_enable (1 bit), dm_write_address (ADDRESS_SIZE) and dm_write_data (DATA_SIZE), all outputs: data-memory write, committed at the rising edge.
REQ-010 The block SHALL have port dm_read_address, output, ADDRESS_SIZE bits, and port dm_read_data, input, DATA_SIZE bits: data-memory combinational read.

Function
REQ-011 The block SHALL be a 5-stage in-order pipeline (IF, ID, EX, MEM, WB) with word-addressed memories, PC += 1 per fetch, and 32 x DATA_SIZE registers with r0 reading 0.
REQ-012 The block SHALL decode MIPS encodings into an internal 4-bit op: 0 NOP; 1 ADD, 2 SUB, 3 AND, 4 OR, 5 SLT (opcode 0, funct 0x20/0x22/0x24/0x25/0x2A); 6 ADDI (0x08); 7 LW (0x23); 8 SW (0x2B); 9 BEQ (0x04); any other encoding, including 0x00000000, SHALL be NOP.
REQ-013 IF SHALL load IF_ID_IR with im_read_data and increment PC every non-stalled cycle.
REQ-014 ID SHALL register ID_EX_A = R[rs], ID_EX_B = R[rt], ID_EX_imm = sign-extended imm16, ID_EX_rd, ID_EX_rt and ID_EX_op; the register read SHALL return the WB value when it is written to the same register in the same cycle.
REQ-015 EX SHALL compute EX_MEM_result as follows: ALU ops are 32-bit wraparound; SLT is a signed compare yielding 1 or 0; LW and SW give A+imm; EX_MEM_B = forwarded B.
REQ-016 EX SHALL set EX_MEM_dest = rd for R-type and rt for ADDI/LW, with EX_MEM_valid = 1 only for register-writing ops.
REQ-017 EX operands SHALL be forwarded from EX_MEM (non-LW, valid, dest != 0) with priority over MEM_WB (valid, dest != 0).
REQ-018 MEM SHALL drive dm_read_address = EX_MEM_result, and MEM_WB_result, MEM_WB_data = dm_read_data, MEM_WB_dest, MEM_WB_op and MEM_WB_valid SHALL be registered from it.
REQ-019 For SW, MEM SHALL drive dm_write_enable = 1, dm_write_address = EX_MEM_result and dm_write_data = EX_MEM_B; otherwise dm_write_enable SHALL be 0.
REQ-020 WB SHALL be combinational: WB_dest = MEM_WB_dest, WB_value = MEM_WB_data for LW else MEM_WB_result, WB_WEenable = MEM_WB_valid && WB_dest != 0; the register file SHALL write on the rising edge.
REQ-021 On a load-use hazard (LW in ID_EX whose rt equals rs or rt of IF_ID_IR) the block SHALL hold PC and IF_ID_IR for 1 cycle, insert a NOP into ID_EX, and assert ex_stall_c = 1 for that cycle.
REQ-022 mem_stall_c SHALL stay 0, because memory is single-cycle.
REQ-023 A BEQ SHALL be resolved in EX; if taken, PC SHALL become (BEQ address + 1 + imm) and IF_ID_IR and ID_EX SHALL be flushed to NOP (2-cycle penalty); if not taken there is no penalty.
REQ-024 A write to r0 SHALL be discarded.
REQ-025 When a branch flush and a load-use stall occur together, the flush SHALL win.

Reset
REQ-026 While reset_n = 0 at a rising edge, the block SHALL clear PC, all pipeline registers (op = NOP, valid = 0), ex_stall_c and mem_stall_c to 0.
REQ-027 Registers r1..r31 SHALL be cleared to 0 on reset.
REQ-028 During reset all dm/im write enables SHALL be 0.
REQ-029 The first fetch after reset_n rises SHALL be from address 0.
REQ-030 Asserting reset mid-program SHALL discard all in-flight instructions with no memory write.

Verification
REQ-031 The bench SHALL cover: IM[0] = ADDI r1,r0,5 after reset -> WB_dest = 1, WB_value = 5, WB_WEenable = 1 at cycle 4.
REQ-032 The bench SHALL cover: ADDI r1,r0,5; ADDI r2,r0,7; ADD r3,r1,r2 (back-to-back, forwarded) -> r3 = 12 with no stall.
REQ-033 The bench SHALL cover: SW r3,0(r0) then LW r4,0(r0); ADD r5,r4,r4 -> DM[0] = 12, one ex_stall_c = 1 cycle, r5 = 24.
REQ-034 The bench SHALL cover: BEQ r0,r0,+2 followed by ADDI r6,r0,1 (x2) and then ADDI r7,r0,9 -> r6 = 0, r7 = 9.
REQ-035 The bench SHALL cover: ADDI r0,r0,3 -> WB_WEenable = 0 and r0 reads 0.
REQ-036 The bench SHALL cover: reset_n low for 1 cycle mid-program -> all valid flags 0, PC = 0, refetch from IM[0].
